spu_issue_scheduler: RTL
========================

// Module: spu_issue_scheduler
// PURPOSE
//  Dual-issue scheduler in front of the SPU register file. Accepts one even/odd instruction pair per
//  handshake from the decoder and keeps a 128-entry scoreboard of pending writebacks. Grants read/issue
//  to each pipe only when its sources are free of hazards. Issue is strictly in order: even before odd.
// PARAMETERS
//  NUM_REGS  128  register file depth; address width is $clog2(NUM_REGS) = 7
//  LAT_W     3    width of per-instruction writeback latency (max 7 cycles)
// PORTS
//  clock            in   1    single clock, rising edge
//  reset            in   1    synchronous, active-low
//  pair_valid       in   1    decoder presents a pair; fields held stable until pair_ready
//  pair_ready       out  1    pair fully consumed this cycle (comb)
//  even_valid       in   1    even slot holds a real instruction (0 = nop)
//  even_src_addr    in   3x7  ra, rb, rc addresses
//  even_src_use     in   3    per-source read enable {ra,rb,rc}
//  even_rt_addr     in   7    destination
//  even_reg_write   in   1    even writes rt
//  even_latency     in   LAT_W cycles until rt written back
//  odd_valid        in   1    odd slot holds a real instruction (0 = lnop)
//  odd_src_addr     in   3x7  ra, rb, rt_st (store data) addresses
//  odd_src_use      in   3    per-source read enable {ra,rb,rt_st}
//  odd_rt_addr      in   7    destination
//  odd_reg_write    in   1    odd writes rt
//  odd_latency      in   LAT_W cycles until rt written back
//  issue_even       out  1    registered: even issued to register file read stage
//  issue_odd        out  1    registered: odd issued
//  issue_even_rt    out  7    registered rt of issued even (valid with issue_even)
//  issue_odd_rt     out  7    registered rt of issued odd
//  stall_cycles     out  16   saturating count of cycles with pair_valid=1 and no issue
// BEHAVIOUR
//  Reset (reset=0 at clock edge): all scoreboard counters=0, FSM=PAIR, all outputs 0, stall_cycles=0.
//  Scoreboard: per register, LAT_W-bit down-counter; nonzero = write pending. Each cycle nonzero -> -1.
//  On issue with reg_write=1: counter[rt] <= max(latency,1); issue overrides the same-cycle decrement.
//  Slot hazard-free when: every used source counter==0 (ready threshold, see CONFIGURATION),
//   and, if reg_write, counter[rt]==0 (WAW blocks issue).
//  Slot with valid=0 always issues trivially; it asserts no issue_* output and touches no counter.
//  FSM states: PAIR (both slots outstanding), ODD_PEND (even done, odd outstanding).
//   PAIR: even free & odd free & no intra-pair dep -> both issue, pair_ready=1, stay PAIR.
//         even free, odd blocked -> even issues, go ODD_PEND, pair_ready=0.
//         even blocked -> nothing issues (odd never overtakes even), stay PAIR.
//   ODD_PEND: odd free -> odd issues, pair_ready=1, go PAIR; else hold.
//  Intra-pair dep: odd used source == even_rt_addr, or odd rt == even rt, with even_reg_write=1.
//   Odd blocks in PAIR; re-evaluated against the scoreboard in ODD_PEND.
//  Decision is combinational on the current scoreboard; issue_* outputs register it (1-cycle latency).
//  pair_valid=0: no issue, FSM holds, counters keep decrementing, stall_cycles unchanged.
//  stall_cycles saturates at 16'hFFFF.
//  Reset asserted mid-pair drops the pair and clears all pending writes.
// CONFIGURATION
//  SPU_SCHED_FWD_EN defined: source ready when counter<=1 (value arrives on the forwarding bus
//   in the read stage). WAW still requires counter==0. Intra-pair dep still blocks odd.
//  Not defined: source ready only when counter==0 (value in register file).
// STRUCTURE
//  spu_sched_pkg: reg_addr_t (7b), lat_t (LAT_W), src_use_t (3b), sched_state_e {PAIR, ODD_PEND},
//   NUM_SRC=3 constant.
//  Sub-module spu_sched_hazard_chk: one instance per slot. Reads scoreboard vector plus slot fields,
//   returns hazard-free flag. Contains the SPU_SCHED_FWD_EN threshold.
// TESTING
//  1 Reset: hold reset=0 3 cycles with pair_valid=1 -> issue_*=0, stall_cycles=0, pair_ready=0.
//  2 Independent pair: even rt=5 lat=2, odd rt=7 lat=4, no deps -> pair_ready same cycle;
//    issue_even=issue_odd=1 next cycle; counters[5]=2, [7]=4.
//  3 RAW across pairs: after 2, even reads ra=5 -> blocked 2 cycles without FWD_EN, 1 cycle with it;
//    stall_cycles increments accordingly.
//  4 Intra-pair: even rt=5, odd rb=5 -> even issues, FSM ODD_PEND; odd issues once counter[5] ready.
//  5 Even blocked (ra=7 pending 4) with odd independent -> odd does not issue until even issues.
//  6 Reset mid-ODD_PEND with counter[5]=3 -> FSM=PAIR, counter[5]=0; next pair reading r5 issues at once.

Source files
------------

// File: rtl/spu_sched_pkg.sv
// Shared types and constants for the SPU dual-issue scheduler.
package spu_sched_pkg;

  localparam int unsigned NUM_REGS = 128;
  localparam int unsigned LAT_W    = 3;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
  localparam int unsigned NUM_SRC  = 3;

  typedef logic [ADDR_W-1:0]  reg_addr_t;
  typedef logic [LAT_W-1:0]   lat_t;
  typedef logic [NUM_SRC-1:0] src_use_t;

  typedef enum logic [0:0] {StPair, StOddPend} sched_state_e;

  // A zero latency still needs one cycle to reach the register file.
  function automatic lat_t lat_min_one(input lat_t lat);
    return (lat == '0) ? lat_t'(1) : lat;
  endfunction

endpackage

// File: rtl/spu_sched_hazard_chk.sv
// Per-slot hazard check against the writeback scoreboard.
// SPU_SCHED_FWD_EN: sources become ready one cycle early via the forwarding bus.
module spu_sched_hazard_chk
  import spu_sched_pkg::*;
(
  input  logic [NUM_REGS-1:0][LAT_W-1:0] i_scoreboard,
  input  logic                           i_valid,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0] i_src_addr,
  input  logic [NUM_SRC-1:0]             i_src_use,
  input  logic [ADDR_W-1:0]              i_rt_addr,
  input  logic                           i_reg_write,
  output logic                           o_free
);

  lat_t w_src_cnt;
  lat_t w_rt_cnt;
  logic w_src_ok;

  always_comb begin
    w_src_ok  = 1'b1;
    w_src_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_src_cnt = i_scoreboard[i_src_addr[i]];
`ifdef SPU_SCHED_FWD_EN
      if (i_src_use[i] && (w_src_cnt > lat_t'(1))) w_src_ok = 1'b0;
`else
      if (i_src_use[i] && (w_src_cnt != '0)) w_src_ok = 1'b0;
`endif
    end
    // WAW always waits for the older write to fully retire.
    w_rt_cnt = i_scoreboard[i_rt_addr];
    o_free   = !i_valid || (w_src_ok && (!i_reg_write || (w_rt_cnt == '0)));
  end

endmodule

// File: rtl/spu_issue_scheduler.sv
// In-order even/odd dual-issue scheduler with a per-register writeback scoreboard.
// Optional SPU_SCHED_FWD_EN (in spu_sched_hazard_chk) relaxes the source-ready threshold.
module spu_issue_scheduler
  import spu_sched_pkg::*;
(
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_pair_valid,
  output logic                           o_pair_ready,
  input  logic                           i_even_valid,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0] i_even_src_addr,
  input  logic [NUM_SRC-1:0]             i_even_src_use,
  input  logic [ADDR_W-1:0]              i_even_rt_addr,
  input  logic                           i_even_reg_write,
  input  logic [LAT_W-1:0]               i_even_latency,
  input  logic                           i_odd_valid,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0] i_odd_src_addr,
  input  logic [NUM_SRC-1:0]             i_odd_src_use,
  input  logic [ADDR_W-1:0]              i_odd_rt_addr,
  input  logic                           i_odd_reg_write,
  input  logic [LAT_W-1:0]               i_odd_latency,
  output logic                           o_issue_even,
  output logic                           o_issue_odd,
  output logic [ADDR_W-1:0]              o_issue_even_rt,
  output logic [ADDR_W-1:0]              o_issue_odd_rt,
  output logic [15:0]                    o_stall_cycles
);

  logic [NUM_REGS-1:0][LAT_W-1:0] r_scoreboard;
  logic [NUM_REGS-1:0][LAT_W-1:0] w_scoreboard_next;
  sched_state_e                   r_state;
  sched_state_e                   w_state_next;
  logic                           r_issue_even;
  logic                           r_issue_odd;
  logic [ADDR_W-1:0]              r_issue_even_rt;
  logic [ADDR_W-1:0]              r_issue_odd_rt;
  logic [15:0]                    r_stall_cycles;

  logic w_even_free;
  logic w_odd_free;
  logic w_intra_dep;
  logic w_even_go;
  logic w_odd_go;
  logic w_even_wr;
  logic w_odd_wr;

  spu_sched_hazard_chk u_even_chk (
    .i_scoreboard (r_scoreboard),
    .i_valid      (i_even_valid),
    .i_src_addr   (i_even_src_addr),
    .i_src_use    (i_even_src_use),
    .i_rt_addr    (i_even_rt_addr),
    .i_reg_write  (i_even_reg_write),
    .o_free       (w_even_free)
  );

  spu_sched_hazard_chk u_odd_chk (
    .i_scoreboard (r_scoreboard),
    .i_valid      (i_odd_valid),
    .i_src_addr   (i_odd_src_addr),
    .i_src_use    (i_odd_src_use),
    .i_rt_addr    (i_odd_rt_addr),
    .i_reg_write  (i_odd_reg_write),
    .o_free       (w_odd_free)
  );

  always_comb begin
    w_intra_dep = 1'b0;
    if (i_even_valid && i_even_reg_write && i_odd_valid) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (i_odd_src_use[i] && (i_odd_src_addr[i] == i_even_rt_addr)) w_intra_dep = 1'b1;
      end
      if (i_odd_reg_write && (i_odd_rt_addr == i_even_rt_addr)) w_intra_dep = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_even_go    = 1'b0;
    w_odd_go     = 1'b0;
    if (i_reset && i_pair_valid) begin
      case (r_state)
        StPair: begin
          // Odd may never overtake a blocked even.
          if (w_even_free) begin
            w_even_go = 1'b1;
            if (w_odd_free && !w_intra_dep) w_odd_go = 1'b1;
            else                            w_state_next = StOddPend;
          end
        end
        StOddPend: begin
          if (w_odd_free) begin
            w_odd_go     = 1'b1;
            w_state_next = StPair;
          end
        end
        default: w_state_next = StPair;
      endcase
    end
    o_pair_ready = w_odd_go;
  end

  assign w_even_wr = w_even_go && i_even_valid && i_even_reg_write;
  assign w_odd_wr  = w_odd_go && i_odd_valid && i_odd_reg_write;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_scoreboard_next[r] = (r_scoreboard[r] != '0) ? r_scoreboard[r] - lat_t'(1) : '0;
    end
    if (w_even_wr) w_scoreboard_next[i_even_rt_addr] = lat_min_one(i_even_latency);
    if (w_odd_wr)  w_scoreboard_next[i_odd_rt_addr]  = lat_min_one(i_odd_latency);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_scoreboard    <= '0;
      r_state         <= StPair;
      r_issue_even    <= 1'b0;
      r_issue_odd     <= 1'b0;
      r_issue_even_rt <= '0;
      r_issue_odd_rt  <= '0;
      r_stall_cycles  <= '0;
    end else begin
      r_scoreboard    <= w_scoreboard_next;
      r_state         <= w_state_next;
      r_issue_even    <= w_even_go && i_even_valid;
      r_issue_odd     <= w_odd_go && i_odd_valid;
      r_issue_even_rt <= (w_even_go && i_even_valid) ? i_even_rt_addr : '0;
      r_issue_odd_rt  <= (w_odd_go && i_odd_valid) ? i_odd_rt_addr : '0;
      if (i_pair_valid && !w_even_go && !w_odd_go && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end
  end

  assign o_issue_even    = r_issue_even;
  assign o_issue_odd     = r_issue_odd;
  assign o_issue_even_rt = r_issue_even_rt;
  assign o_issue_odd_rt  = r_issue_odd_rt;
  assign o_stall_cycles  = r_stall_cycles;

endmodule
